// File: rtl/mem_bank_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bank_ctrl
// Single-port synchronous memory with a valid/ready request handshake, byte
// enables, a configurable read latency and out-of-range error reporting.
// After every reset the array is filled with INIT_VAL, one word per cycle,
// before any request is accepted.
//
// Ports
//   clk       clock, all logic on posedge
//   rst       asynchronous active-high reset
//   valid_i   request valid
//   wr_rd_i   1 = write, 0 = read
//   addr_i    word address
//   wdata_i   write data
//   be_i      byte enables, bit n selects wdata_i[8n+7:8n]
//   ready_o   request can be accepted this cycle
//   rdata_o   read data, valid while rvalid_o = 1, holds between responses
//   rvalid_o  one-cycle read-response pulse
//   err_o     one-cycle pulse for an out-of-range access
// -----------------------------------------------------------------------------
module mem_bank_ctrl #(
  parameter int               WIDTH      = 32,
  parameter int               ADDR_WIDTH = 6,
  parameter int               DEPTH      = 64,
  parameter int               RD_LAT     = 1,
  parameter logic [WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [WIDTH/8-1:0]    be_i,
  output logic                  ready_o,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rvalid_o,
  output logic                  err_o
);

  localparam int NBYTES = WIDTH / 8;
  // One extra bit so DEPTH = 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [2:0]            LAT_W     = 3'(RD_LAT);

  typedef enum logic [1:0] {INIT, IDLE, RD_WAIT} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] init_cnt_reg;
  logic [ADDR_WIDTH-1:0] rd_addr_reg;
  logic                  rd_oob_reg;
  logic [2:0]            lat_cnt_reg;

  logic                  accept, wr_accept, rd_accept, addr_in_range;
  logic                  rd_fire;
  logic [ADDR_WIDTH-1:0] rd_src_addr;
  logic                  rd_src_oob;

  logic [WIDTH-1:0] mem [DEPTH];

  assign ready_o       = (state_reg == IDLE);
  assign accept        = valid_i & ready_o;
  assign wr_accept     = accept & wr_rd_i;
  assign rd_accept     = accept & ~wr_rd_i;
  assign addr_in_range = ({1'b0, addr_i} < DEPTH_W);

  // Next state plus the read-fire decision. rd_fire marks the edge that
  // registers the response, so rvalid_o shows up RD_LAT cycles after the
  // acceptance edge. With RD_LAT = 1 that edge is the acceptance edge itself,
  // so the FSM never leaves IDLE for a read.
  always_comb begin
    state_next  = state_reg;
    rd_fire     = 1'b0;
    rd_src_addr = rd_addr_reg;
    rd_src_oob  = rd_oob_reg;
    case (state_reg)
      INIT: begin
        if (init_cnt_reg == LAST_ADDR) state_next = IDLE;
      end
      IDLE: begin
        if (rd_accept) begin
          rd_src_addr = addr_i;
          rd_src_oob  = ~addr_in_range;
          if (RD_LAT == 1) rd_fire = 1'b1;
          else             state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Counter was loaded with RD_LAT; firing at 2 puts the registered
        // response in the RD_LAT-th cycle after acceptance.
        if (lat_cnt_reg == 3'd2) begin
          rd_fire    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= INIT;
      init_cnt_reg <= '0;
      rd_addr_reg  <= '0;
      rd_oob_reg   <= 1'b0;
      lat_cnt_reg  <= '0;
      rvalid_o     <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state_reg <= state_next;
      rvalid_o  <= rd_fire;
      // Write errors pulse right after acceptance; read errors ride with rvalid_o.
      err_o     <= (wr_accept & ~addr_in_range) | (rd_fire & rd_src_oob);
      if (state_reg == INIT) init_cnt_reg <= init_cnt_reg + 1'b1;
      if (rd_accept) begin
        rd_addr_reg <= addr_i;
        rd_oob_reg  <= ~addr_in_range;
        lat_cnt_reg <= LAT_W;
      end else if (state_reg == RD_WAIT) begin
        lat_cnt_reg <= lat_cnt_reg - 1'b1;
      end
    end
  end

  // Registered read port; out-of-range reads return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_o <= '0;
    end else if (rd_fire) begin
      rdata_o <= rd_src_oob ? '0 : mem[rd_src_addr];
    end
  end

  // Array write port: initialisation sweep, then byte-masked writes.
  // Out-of-range writes and be_i = 0 leave the array untouched.
  always_ff @(posedge clk) begin
    if (state_reg == INIT) begin
      mem[init_cnt_reg] <= INIT_VAL;
    end else if (wr_accept && addr_in_range) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bank_ctrl
// Drives directed and random requests into mem_bank_ctrl. Each accepted
// request that must produce an output pushes its expected response into a
// queue; a separate monitor pops and compares whenever rvalid_o or err_o fires.
// The reference memory is a plain array updated with the byte-enable rules.
// -----------------------------------------------------------------------------
module tb_mem_bank_ctrl;

  localparam int          WIDTH  = 32;
  localparam int          AW     = 6;
  localparam int          DEPTH  = 48;
  localparam int          RD_LAT = 2;
  localparam logic [31:0] INIT_V = 32'hA5A5_0F0F;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_i = 1'b0;
  logic          wr_rd_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [31:0]   wdata_i = '0;
  logic [3:0]    be_i = '0;
  logic          ready_o;
  logic [31:0]   rdata_o;
  logic          rvalid_o;
  logic          err_o;

  mem_bank_ctrl #(
    .WIDTH(WIDTH), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .INIT_VAL(INIT_V)
  ) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .wr_rd_i(wr_rd_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .ready_o(ready_o), .rdata_o(rdata_o),
    .rvalid_o(rvalid_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [64];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = (i < DEPTH) ? INIT_V : 32'h0;
  endtask

  // Issue one request, hold it until accepted, and record expectations.
  // Returns the number of cycles ready_o was low while the request waited.
  task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] be, output int waited);
    exp_t e;
    waited  = 0;
    valid_i = 1'b1;
    wr_rd_i = wr;
    addr_i  = a;
    wdata_i = d;
    be_i    = be;
    @(negedge clk);
    while (!ready_o && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready_o=0 expected 1 within 200 cycles");
      valid_i = 1'b0;
      return;
    end
    // Accepted at the coming posedge, edge number cyc+1.
    if (wr) begin
      if (a < DEPTH) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
      end else begin
        e.rd = 1'b0; e.err = 1'b1; e.data = 32'h0; e.due = cyc + 1;
        exp_q.push_back(e);
      end
    end else begin
      e.rd   = 1'b1;
      e.err  = (a >= DEPTH);
      e.data = (a < DEPTH) ? model[a] : 32'h0;
      e.due  = cyc + RD_LAT;
      exp_q.push_back(e);
    end
    $display("req %s addr=%0d data=%h be=%b", wr ? "WR" : "RD", a, d, be);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  // Monitor: every response or error pulse must match the head of the queue,
  // and nothing expected may go overdue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rvalid_o || err_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got rvalid=%0b err=%0b expected none", rvalid_o, err_o);
          end else begin
            e = exp_q.pop_front();
            check("rsp_rvalid", {31'h0, rvalid_o}, {31'h0, e.rd});
            check("rsp_err", {31'h0, err_o}, {31'h0, e.err});
            check("rsp_cycle", cyc, e.due);
            if (e.rd) check("rsp_rdata", rdata_o, e.data);
            $display("rsp rvalid=%0b err=%0b rdata=%h", rvalid_o, err_o, rdata_o);
          end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
          e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_output: got nothing expected rd=%0b err=%0b by cycle %0d", e.rd, e.err, e.due);
        end
      end
    end
  end

  // Counts cycles of ready_o = 0 starting at the next negedge, bounded.
  task automatic count_ready_low(output int n);
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 500) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int w, n, sum;
    logic [AW-1:0] a;
    model_reset();

    // Reset state after clock edges under reset
    repeat (3) @(negedge clk);
    check("reset_ready", {31'h0, ready_o}, 32'h0);
    check("reset_rvalid", {31'h0, rvalid_o}, 32'h0);
    check("reset_err", {31'h0, err_o}, 32'h0);
    check("reset_rdata", rdata_o, 32'h0);

    // 1. Initialisation length, then initialised contents
    @(posedge clk); #1;
    rst = 1'b0;
    count_ready_low(n);
    check("init_ready_low_cycles", n, DEPTH);
    @(posedge clk); #1;
    do_req(1'b0, 6'd5, 32'h0, 4'h0, w);

    // 2. Full write then read; ready_o drops for RD_LAT-1 cycles
    do_req(1'b1, 6'd3, 32'hDEAD_BEEF, 4'hF, w);
    do_req(1'b0, 6'd3, 32'h0, 4'h0, w);
    count_ready_low(n);
    check("read_ready_low_cycles", n, RD_LAT - 1);
    @(posedge clk); #1;

    // 3. Partial byte write
    do_req(1'b1, 6'd3, 32'h1122_3344, 4'b0101, w);
    do_req(1'b0, 6'd3, 32'h0, 4'h0, w);
    check("model_merge_sanity", model[3], 32'hDE22_BE44);

    // 4. Out-of-range write and read, be=0 write, and neighbours unchanged
    do_req(1'b1, 6'd50, 32'hCAFE_F00D, 4'hF, w);
    do_req(1'b0, 6'd63, 32'h0, 4'h0, w);
    do_req(1'b1, 6'd4, 32'h1234_5678, 4'h0, w);
    do_req(1'b0, 6'd4, 32'h0, 4'h0, w);
    do_req(1'b0, 6'd2, 32'h0, 4'h0, w);
    do_req(1'b0, 6'd18, 32'h0, 4'h0, w);
    do_req(1'b0, 6'd47, 32'h0, 4'h0, w);
    do_req(1'b0, 6'd48, 32'h0, 4'h0, w);

    // 5. Back-to-back writes keep ready_o high
    repeat (3) @(posedge clk);
    #1;
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      a = AW'(i);
      do_req(1'b1, a, 32'(i + 1), 4'hF, w);
      sum += w;
    end
    check("burst_ready_low_cycles", sum, 0);
    for (int i = 0; i < 8; i++) begin
      a = AW'(i);
      do_req(1'b0, a, 32'h0, 4'h0, w);
    end

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      a = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = AW'($urandom_range(0, DEPTH - 1));
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), w);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    repeat (6) @(negedge clk);
    check("queue_drained_random", exp_q.size(), 0);

    // 6. Reset while a read is in flight
    @(posedge clk); #1;
    do_req(1'b1, 6'd3, 32'h5555_AAAA, 4'hF, w);
    do_req(1'b0, 6'd3, 32'h0, 4'h0, w);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_ready", {31'h0, ready_o}, 32'h0);
    check("midrst_rvalid", {31'h0, rvalid_o}, 32'h0);
    check("midrst_err", {31'h0, err_o}, 32'h0);
    check("midrst_rdata", rdata_o, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    count_ready_low(n);
    check("reinit_ready_low_cycles", n, DEPTH);
    @(posedge clk); #1;
    do_req(1'b0, 6'd3, 32'h0, 4'h0, w);
    do_req(1'b0, 6'd0, 32'h0, 4'h0, w);
    repeat (6) @(negedge clk);
    check("queue_drained_final", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
